dmux4way16_dispatch: RTL and testbench

- Sequencing controller for the 4-way 16-bit demultiplexer datapath.
- Accepts 16-bit words on a valid/ready input and routes each word to exactly one of four destination ports a/b/c/d through a one-word holding register.
- Destination comes from strict round-robin or from an explicit per-word address.
- Non-selected ports always read zero, which preserves the DMux output semantics. Also tracks delivered-word count and destination stalls.

---
 rtl/dmux4way16_dispatch_if.sv | 31 +++
 rtl/dmux4way16_dispatch.sv | 111 +++++++++++
 tb/tb_dmux4way16_dispatch.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dmux4way16_dispatch_if.sv
// rtl/dmux4way16_dispatch_if.sv - word input handshake and four-port demux output bundle
interface dmux4way16_dispatch_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] in;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_dest;
   logic             mode;
   logic [3:0]       out_ready;
   logic [3:0]       out_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [1:0]       sel;
   logic [15:0]      count;
   logic             stall;

   // Word source and destination sinks.
   modport master (
      output in, in_valid, in_dest, mode, out_ready,
      input  in_ready, out_valid, a, b, c, d, sel, count, stall
   );

   // Dispatcher.
   modport slave (
      input  in, in_valid, in_dest, mode, out_ready,
      output in_ready, out_valid, a, b, c, d, sel, count, stall
   );
endinterface

// File: rtl/dmux4way16_dispatch.sv
// rtl/dmux4way16_dispatch.sv - one-word holding dispatcher onto four demux ports
module dmux4way16_dispatch #(
   parameter int WIDTH       = 16,
   parameter int STALL_LIMIT = 8
) (
   input logic                 clk,
   input logic                 reset,
   dmux4way16_dispatch_if.slave bus
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [8:0] STALL_LIM9 = 9'(STALL_LIMIT);

   state_t           state;
   logic [WIDTH-1:0] hold;
   logic [1:0]       sel;
   logic [1:0]       rr_ptr;
   logic             rr_word;
   logic [15:0]      count;
   logic [7:0]       stall_cnt;
   logic             stall;
   logic [3:0]       out_valid;

   logic             done;
   logic [1:0]       rr_next;
   logic [1:0]       cap_sel;

   // Completion, the round-robin pointer as it will be after a completion,
   // and the target a word captured this cycle would get.
   always_comb begin
      done    = (state == SEND) && bus.out_ready[sel];
      rr_next = rr_ptr;
      if (state == SEND && rr_word) begin
         rr_next = sel + 2'd1;
      end
      cap_sel = bus.mode ? bus.in_dest : rr_next;
   end

   // Control FSM: capture, hold until the target is ready, track count and stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         hold      <= '0;
         sel       <= 2'd0;
         rr_ptr    <= 2'd0;
         rr_word   <= 1'b0;
         count     <= 16'd0;
         stall_cnt <= 8'd0;
         stall     <= 1'b0;
         out_valid <= 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  hold      <= bus.in;
                  sel       <= cap_sel;
                  rr_word   <= ~bus.mode;
                  out_valid <= 4'b0001 << cap_sel;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (done) begin
                  count     <= count + 16'd1;
                  rr_ptr    <= rr_next;
                  stall_cnt <= 8'd0;
                  stall     <= 1'b0;
                  if (bus.in_valid) begin
                     // Back-to-back: next word captured on the completing edge.
                     hold      <= bus.in;
                     sel       <= cap_sel;
                     rr_word   <= ~bus.mode;
                     out_valid <= 4'b0001 << cap_sel;
                  end else begin
                     out_valid <= 4'b0000;
                     state     <= IDLE;
                  end
               end else begin
                  // Target not ready: word waits indefinitely, only the stall tracker moves.
                  if (stall_cnt != 8'hFF) begin
                     stall_cnt <= stall_cnt + 8'd1;
                  end
                  if (({1'b0, stall_cnt} + 9'd1) >= STALL_LIM9) begin
                     stall <= 1'b1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 4'b0000;
            end
         endcase
      end
   end

   // Demux outputs: only the valid port carries the held word, the rest read zero.
   always_comb begin
      bus.a = out_valid[0] ? hold : '0;
      bus.b = out_valid[1] ? hold : '0;
      bus.c = out_valid[2] ? hold : '0;
      bus.d = out_valid[3] ? hold : '0;
   end

   assign bus.in_ready  = (state == IDLE) ? 1'b1 : bus.out_ready[sel];
   assign bus.out_valid = out_valid;
   assign bus.sel       = sel;
   assign bus.count     = count;
   assign bus.stall     = stall;

endmodule

// File: tb/tb_dmux4way16_dispatch.sv
// tb/tb_dmux4way16_dispatch.sv - scoreboard bench for dmux4way16_dispatch
module tb_dmux4way16_dispatch;

   typedef struct {
      logic [1:0]  port;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   exp_t q[$];
   logic [1:0] model_rr = 2'd0;

   dmux4way16_dispatch_if #(.WIDTH(16)) bus_if ();

   dmux4way16_dispatch #(.WIDTH(16), .STALL_LIMIT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one word, wait (bounded) for acceptance, then record the expected destination.
   task automatic send(input logic [15:0] dat, input logic m, input logic [1:0] dst, output int waited);
      exp_t e;
      bus_if.in       = dat;
      bus_if.mode     = m;
      bus_if.in_dest  = dst;
      bus_if.in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (bus_if.in_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) chk("accept_timeout", {63'd0, bus_if.in_ready}, 64'd1);
      e.port = m ? dst : model_rr;
      e.data = dat;
      if (!m) model_rr = model_rr + 2'd1;
      @(posedge clk);
      q.push_back(e);
      #1;
      bus_if.in_valid = 1'b0;
   endtask

   // Output monitor: the front of the scoreboard must be on exactly its port.
   always @(negedge clk) begin
      if (!reset) begin
         if (q.size() == 0) begin
            chk("idle_out_valid", {60'd0, bus_if.out_valid}, 64'd0);
            chk("idle_ports", {bus_if.d, bus_if.c, bus_if.b, bus_if.a}, 64'd0);
         end else begin
            chk("sel", {62'd0, bus_if.sel}, {62'd0, q[0].port});
            chk("out_valid", {60'd0, bus_if.out_valid}, 64'd1 << q[0].port);
            chk("ports", {bus_if.d, bus_if.c, bus_if.b, bus_if.a},
                {48'd0, q[0].data} << (16 * q[0].port));
            if (bus_if.out_ready[q[0].port]) void'(q.pop_front());
         end
      end
   end

   initial begin
      int w;
      logic [15:0] words[5];
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
      words[3] = 16'h4444; words[4] = 16'h5555;
      bus_if.in = '0;
      bus_if.in_valid = 1'b0;
      bus_if.in_dest = 2'd0;
      bus_if.mode = 1'b0;
      bus_if.out_ready = 4'b1111;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {60'd0, bus_if.out_valid}, 64'd0);
      chk("rst_ports", {bus_if.d, bus_if.c, bus_if.b, bus_if.a}, 64'd0);
      chk("rst_sel", {62'd0, bus_if.sel}, 64'd0);
      chk("rst_count", {48'd0, bus_if.count}, 64'd0);
      chk("rst_stall", {63'd0, bus_if.stall}, 64'd0);
      reset = 1'b0;
      chk("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);

      // Round-robin back-to-back burst
      for (int i = 0; i < 5; i++) begin
         send(words[i], 1'b0, 2'd0, w);
         chk("burst_accept_wait", 64'(w), 64'd0);
      end
      @(posedge clk); #1;
      chk("burst_count", {48'd0, bus_if.count}, 64'd5);
      chk("burst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);

      // Addressed word to c with c not ready: hold, stall, then release
      bus_if.out_ready = 4'b1011;
      send(16'h0426, 1'b1, 2'd2, w);
      chk("addr_out_valid", {60'd0, bus_if.out_valid}, 64'h4);
      chk("addr_c", {48'd0, bus_if.c}, 64'h0426);
      chk("addr_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         chk("stall_early", {63'd0, bus_if.stall}, 64'd0);
      end
      @(posedge clk); #1;
      chk("stall_set", {63'd0, bus_if.stall}, 64'd1);
      chk("stall_hold_c", {48'd0, bus_if.c}, 64'h0426);
      chk("stall_count", {48'd0, bus_if.count}, 64'd5);
      bus_if.out_ready = 4'b1111;
      @(posedge clk); #1;
      chk("release_count", {48'd0, bus_if.count}, 64'd6);
      chk("release_stall", {63'd0, bus_if.stall}, 64'd0);

      // Round-robin stall on b with the next word held at the input
      bus_if.out_ready = 4'b1101;
      send(16'h1D97, 1'b0, 2'd0, w);
      bus_if.in = 16'hAAAA;
      bus_if.mode = 1'b0;
      bus_if.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rr_stall_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
      end
      @(posedge clk); #1;
      bus_if.out_ready = 4'b1111;
      @(negedge clk);
      chk("rr_release_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
      @(posedge clk);
      q.push_back('{port: model_rr, data: 16'hAAAA});
      model_rr = model_rr + 2'd1;
      #1;
      bus_if.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rr_count", {48'd0, bus_if.count}, 64'd8);

      // Mode/in_dest changed while the word waits: delivery stays on b
      bus_if.out_ready = 4'b1101;
      send(16'h5A5A, 1'b1, 2'd1, w);
      bus_if.mode = 1'b0;
      bus_if.in_dest = 2'd3;
      repeat (2) begin @(posedge clk); #1; end
      chk("chg_out_valid", {60'd0, bus_if.out_valid}, 64'h2);
      chk("chg_b", {48'd0, bus_if.b}, 64'h5A5A);
      chk("chg_d", {48'd0, bus_if.d}, 64'd0);
      bus_if.out_ready = 4'b1111;
      @(posedge clk); #1;
      chk("chg_count", {48'd0, bus_if.count}, 64'd9);

      // Reset while d holds 0xFFFF
      bus_if.out_ready = 4'b0111;
      send(16'hFFFF, 1'b0, 2'd0, w);
      @(posedge clk); #1;
      chk("pre_rst_d", {48'd0, bus_if.d}, 64'hFFFF);
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", {60'd0, bus_if.out_valid}, 64'd0);
      chk("mid_rst_d", {48'd0, bus_if.d}, 64'd0);
      chk("mid_rst_sel", {62'd0, bus_if.sel}, 64'd0);
      chk("mid_rst_count", {48'd0, bus_if.count}, 64'd0);
      q.delete();
      model_rr = 2'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      bus_if.out_ready = 4'b1111;
      chk("post_rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
      send(16'h0BAD, 1'b0, 2'd0, w);
      @(posedge clk); #1;
      chk("post_rst_count", {48'd0, bus_if.count}, 64'd1);

      // Count wrap: 65535 words from reset, then one more
      reset = 1'b1;
      #1;
      q.delete();
      model_rr = 2'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         send(16'(i) ^ 16'h5A5A, 1'b0, 2'd0, w);
      end
      @(posedge clk); #1;
      chk("preload_count", {48'd0, bus_if.count}, 64'hFFFF);
      chk("preload_stall", {63'd0, bus_if.stall}, 64'd0);
      send(16'hBEEF, 1'b0, 2'd0, w);
      @(posedge clk); #1;
      chk("wrap_count", {48'd0, bus_if.count}, 64'd0);
      chk("wrap_stall", {63'd0, bus_if.stall}, 64'd0);
      chk("wrap_out_valid", {60'd0, bus_if.out_valid}, 64'd0);
      chk("wrap_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
      chk("scoreboard_empty", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
